// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared FSM state and owner codes for the memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_ACK   = 2'd3
    } arb_state_e;

    localparam logic OWNER_FETCH = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    // Wide enough for the largest legal read latency of 15.
    localparam int CNT_WIDTH = 4;

endpackage

// File: rtl/mem_arb_select.sv
// rtl/mem_arb_select.sv - picks the winner between fetch and data requests
// MEM_ARB_ROUND_ROBIN_EN: alternate on contention using last_owner_i; otherwise data wins.
module mem_arb_select
    import mem_arbiter_pkg::*;
(
    input  logic if_req_i,
    input  logic d_req_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic last_owner_i,
`endif
    output logic req_any_o,
    output logic winner_o
);

    assign req_any_o = if_req_i | d_req_i;

    always_comb begin
        winner_o = OWNER_FETCH;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (if_req_i && d_req_i) begin
            winner_o = ~last_owner_i;
        end else if (d_req_i) begin
            winner_o = OWNER_DATA;
        end
`else
        if (d_req_i) begin
            winner_o = OWNER_DATA;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between instruction fetch and load/store
// MEM_ARB_ROUND_ROBIN_EN: builds the last-owner register for alternating grants.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  owner
);

    localparam logic [CNT_WIDTH-1:0] LAT_CNT = CNT_WIDTH'(MEM_LATENCY);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    arb_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  req_any;
    logic                  winner;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                  last_q, last_d;
`endif

    mem_arb_select u_select (
        .if_req_i     (if_req),
        .d_req_i      (d_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_owner_i (last_q),
`endif
        .req_any_o    (req_any),
        .winner_o     (winner)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d     = last_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (req_any) begin
                    state_d = ARB_ISSUE;
                    owner_d = winner;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d  = winner;
`endif
                    if (winner == OWNER_DATA) begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                    end else begin
                        addr_d  = if_addr;
                        we_d    = 1'b0;
                    end
                end
            end
            ARB_ISSUE: begin
                cnt_d   = LAT_CNT;
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                // Counter reaching zero on this edge is the edge mem_rdata is valid.
                if (cnt_q == CNT_ONE) begin
                    state_d = ARB_ACK;
                    if (!we_q) begin
                        if (owner_q == OWNER_DATA) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            ARB_ACK: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ARB_IDLE;
            cnt_q      <= '0;
            owner_q    <= OWNER_FETCH;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q     <= OWNER_DATA;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    assign mem_en    = (state_q == ARB_ISSUE);
    assign if_ack    = (state_q == ARB_ACK) && (owner_q == OWNER_FETCH);
    assign d_ack     = (state_q == ARB_ACK) && (owner_q == OWNER_DATA);
    assign busy      = (state_q != ARB_IDLE);
    assign owner     = owner_q;
    assign mem_addr  = addr_q;
    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (MEM_ARB_ROUND_ROBIN_EN aware)
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic          if_req  = 1'b0;
    logic          d_req   = 1'b0;
    logic          d_we    = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [AW-1:0] d_addr  = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          if_ack, d_ack, mem_en, mem_we, busy, owner;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .owner     (owner)
    );

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return (a == 16'h0010) ? 16'hABCD : {a[7:0], ~a[7:0]};
    endfunction

    // Read data is valid for exactly one edge, LAT edges after mem_en is sampled.
    logic [DW-1:0] rd_pipe [LAT];
    always @(posedge clock) begin
        rd_pipe[0] <= mem_en ? mem_fn(mem_addr) : 16'hDEAD;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    typedef struct {
        logic          own;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            req_edge;
    } exp_t;

    typedef struct {
        logic          is_d;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            n_en     = 0;
    int            n_grant  = 0;
    logic [DW-1:0] d_rdata_exp = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_access(input logic own, input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                                 input int req_edge);
        exp_t e;
        e.own = own; e.we = we; e.addr = addr; e.wdata = wdata;
        e.rdata = rdata; e.req_edge = req_edge;
        sb.push_back(e);
        n_grant++;
    endtask

    // One clock; outputs observed 1 time unit after the rising edge, cyc = edges so far.
    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        cyc++;
        check("dual_ack", {31'd0, if_ack & d_ack}, 0);
        if (mem_en) begin
            n_en++;
            check("en_with_pending", {31'd0, sb.size() != 0}, 1);
            if (sb.size() != 0) begin
                check("mem_addr", mem_addr, sb[0].addr);
                check("mem_we", mem_we, sb[0].we);
                if (sb[0].we) check("mem_wdata", mem_wdata, sb[0].wdata);
                if (sb[0].req_edge >= 0) check("en_edge", cyc, sb[0].req_edge);
            end
        end
        if (if_ack || d_ack) begin
            check("ack_with_pending", {31'd0, sb.size() != 0}, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("ack_owner", d_ack, e.own);
                check("owner", owner, e.own);
                if (e.req_edge >= 0) check("ack_latency", cyc + 1 - e.req_edge, LAT + 2);
                if (e.own == OWNER_FETCH) begin
                    check("if_rdata", if_rdata, e.rdata);
                end else if (!e.we) begin
                    check("d_rdata", d_rdata, e.rdata);
                    d_rdata_exp = e.rdata;
                end else begin
                    check("d_rdata_held", d_rdata, d_rdata_exp);
                end
            end
        end
    endtask

    task automatic wait_ack(input string name);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!(if_ack || d_ack) && k < 40);
        check({name, "_ack_seen"}, {31'd0, if_ack | d_ack}, 1);
    endtask

    initial begin
        vec_t vt[6];
        vt[0] = '{is_d: 1'b0, we: 1'b0, addr: 16'h0010, wdata: 16'h0000, exp_rdata: 16'hABCD};
        vt[1] = '{is_d: 1'b1, we: 1'b1, addr: 16'h0200, wdata: 16'h1234, exp_rdata: 16'h0000};
        vt[2] = '{is_d: 1'b1, we: 1'b0, addr: 16'h0033, wdata: 16'h0000, exp_rdata: 16'h33CC};
        vt[3] = '{is_d: 1'b0, we: 1'b0, addr: 16'h00FF, wdata: 16'h0000, exp_rdata: 16'hFF00};
        vt[4] = '{is_d: 1'b1, we: 1'b0, addr: 16'h0010, wdata: 16'h0000, exp_rdata: 16'hABCD};
        vt[5] = '{is_d: 1'b1, we: 1'b1, addr: 16'hFFFF, wdata: 16'hFFFF, exp_rdata: 16'h0000};

        // Reset held with both requesters active.
        reset_n = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        if_addr = 16'h0010; d_addr = 16'h0020; d_wdata = 16'h5555;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_mem_en", {31'd0, mem_en}, 0);
            check("rst_busy", {31'd0, busy}, 0);
            check("rst_owner", {31'd0, owner}, 0);
            check("rst_acks", {30'd0, if_ack, d_ack}, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_we", {31'd0, mem_we}, 0);
            check("rst_mem_wdata", mem_wdata, 0);
            check("rst_rdata", {if_rdata, d_rdata}, 0);
        end

        reset_n = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        expect_access(OWNER_FETCH, 1'b0, 16'h0010, 16'h0000, 16'hABCD, cyc + 1);
`else
        expect_access(OWNER_DATA, 1'b1, 16'h0020, 16'h5555, 16'h0000, cyc + 1);
`endif
        wait_ack("post_reset");
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        tick();

        foreach (vt[i]) begin
            if (vt[i].is_d) begin
                d_req = 1'b1; d_we = vt[i].we; d_addr = vt[i].addr; d_wdata = vt[i].wdata;
            end else begin
                if_req = 1'b1; if_addr = vt[i].addr;
            end
            expect_access(vt[i].is_d, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_rdata, cyc + 1);
            wait_ack("vec");
            if_req = 1'b0; d_req = 1'b0;
            tick();
            check("vec_idle_busy", {31'd0, busy}, 0);
        end

        // Contention: both held for four grants (last grant above was data).
        if_req = 1'b1; if_addr = 16'h0010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0021;
        for (int g = 0; g < 4; g++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (g % 2 == 0) expect_access(OWNER_FETCH, 1'b0, 16'h0010, 16'h0000, 16'hABCD, -1);
            else            expect_access(OWNER_DATA, 1'b0, 16'h0021, 16'h0000, mem_fn(16'h0021), -1);
`else
            expect_access(OWNER_DATA, 1'b0, 16'h0021, 16'h0000, mem_fn(16'h0021), -1);
`endif
        end
        for (int g = 0; g < 4; g++) wait_ack("contend");
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if_req = 1'b0; d_req = 1'b0;
`else
        d_req = 1'b0;
        expect_access(OWNER_FETCH, 1'b0, 16'h0010, 16'h0000, 16'hABCD, -1);
        wait_ack("contend_tail");
        if_req = 1'b0;
`endif
        tick();
        check("contend_drained", sb.size(), 0);

        // Back-to-back fetches with one IDLE bubble.
        if_req = 1'b1; if_addr = 16'h0040;
        expect_access(OWNER_FETCH, 1'b0, 16'h0040, 16'h0000, mem_fn(16'h0040), cyc + 1);
        wait_ack("b2b_first");
        if_addr = 16'h0041;
        expect_access(OWNER_FETCH, 1'b0, 16'h0041, 16'h0000, mem_fn(16'h0041), cyc + 2);
        tick();
        check("b2b_gap_busy", {31'd0, busy}, 0);
        check("b2b_gap_en", {31'd0, mem_en}, 0);
        tick();
        check("b2b_next_en", {31'd0, mem_en}, 1);
        check("b2b_next_busy", {31'd0, busy}, 1);
        wait_ack("b2b_second");
        if_req = 1'b0;
        tick();

        // Reset asserted in the second WAIT cycle discards the access.
        if_req = 1'b1; if_addr = 16'h0050;
        expect_access(OWNER_FETCH, 1'b0, 16'h0050, 16'h0000, mem_fn(16'h0050), cyc + 1);
        tick();
        tick();
        tick();
        check("midwait_busy", {31'd0, busy}, 1);
        reset_n = 1'b0; if_req = 1'b0;
        tick();
        check("midwait_no_ack", {30'd0, if_ack, d_ack}, 0);
        check("midwait_busy_rst", {31'd0, busy}, 0);
        check("midwait_if_rdata", if_rdata, 0);
        sb.delete();
        d_rdata_exp = '0;
        tick();
        reset_n = 1'b1; if_req = 1'b1; if_addr = 16'h0060;
        expect_access(OWNER_FETCH, 1'b0, 16'h0060, 16'h0000, mem_fn(16'h0060), cyc + 1);
        wait_ack("after_midwait");
        if_req = 1'b0;
        tick();

        check("en_count", n_en, n_grant);
        check("final_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port program/data memory between the CPU's instruction-fetch path and its load/store path. Each requester gets a request/acknowledge handshake. The arbiter issues one access at a time to the memory, waits a fixed read latency, then returns read data with a one-cycle acknowledge. It sits between the control FSM's FETCH/LOAD/STORE phases and the memory array.

## Interface
- `ADDR_WIDTH`, default 16: memory word-address width.
- `DATA_WIDTH`, default 16: memory word width.
- `MEM_LATENCY`, default 1: cycles from the edge at which the memory samples `mem_en` to the edge at which `mem_rdata` is valid. Legal range is 1 to 15.

Ports (one clock; reset is synchronous and active-low):
- `clock` in 1: the single clock; all state updates on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `if_req` in 1: fetch request. Held high with `if_addr` stable until `if_ack`.
- `if_addr` in ADDR_WIDTH: fetch address.
- `if_ack` out 1: one-cycle pulse; `if_rdata` is valid in the same cycle.
- `if_rdata` out DATA_WIDTH: fetched word, registered.
- `d_req` in 1: data request. Held high with `d_we`/`d_addr`/`d_wdata` stable until `d_ack`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_WIDTH: data address.
- `d_wdata` in DATA_WIDTH: store data.
- `d_ack` out 1: one-cycle pulse; `d_rdata` is valid in the same cycle (loads only).
- `d_rdata` out DATA_WIDTH: loaded word, registered.
- `mem_en` out 1: one-cycle access strobe.
- `mem_we` out 1: write enable, qualified by `mem_en`.
- `mem_addr` out ADDR_WIDTH: memory address, registered.
- `mem_wdata` out DATA_WIDTH: memory write data, registered.
- `mem_rdata` in DATA_WIDTH: memory read data.
- `busy` out 1: high in every state except IDLE.
- `owner` out 1: current or last grant; 0 = fetch, 1 = data.

## Operation
- FSM states:
  - IDLE: if any request is high, select a winner, latch its address, write enable and write data into the `mem_*` registers, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `mem_en` = 1 for exactly this cycle. Load the wait counter with MEM_LATENCY. Go to WAIT.
  - WAIT: decrement the counter. When it reaches 0, capture `mem_rdata` into the owner's rdata register (loads and fetches only) and go to ACK.
  - ACK: assert the owner's ack for this cycle. Always go to IDLE, never directly to ISSUE, so a requester dropping `req` at that edge cannot cause a stale re-grant.
- Fetch accesses always drive `mem_we` = 0. Data accesses drive `mem_we` = `d_we`.
- Stores still run through WAIT and ACK; their rdata register is left unchanged.
- Arbitration when both requests are high in IDLE: the data request wins (fixed priority), unless the feature under Configuration is enabled.
- `mem_addr`, `mem_we` and `mem_wdata` hold their latched values until the next grant.
- If a requester drops `req` before its ack, that is a protocol violation. The access still completes and the ack still pulses.
- Reset values: every output 0, FSM in IDLE, counter 0, `owner` 0.
- Reset in any state discards the in-flight access with no ack. Requests are served normally from the first cycle after reset deasserts.

## Timing
- A request sampled high in IDLE at edge E0 produces:
  - `mem_en` high during cycle E0–E1;
  - read data captured at edge E(1+MEM_LATENCY);
  - ack high during the following cycle.
- Latency from request sample to ack cycle is MEM_LATENCY+2 cycles.
- A full access, including the idle bubble, takes MEM_LATENCY+3 cycles. The minimum gap is one IDLE cycle between an ack and the next `mem_en`.
- `if_ack` and `d_ack` are never high in the same cycle.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: on contention the grant alternates. A one-bit last-owner register picks whichever requester was not granted last. Its reset value is "data last", so fetch wins the first contention after reset. Uncontested grants also update the register.
- `MEM_ARB_ROUND_ROBIN_EN` undefined: fixed priority, data over fetch. The last-owner register is not built.

## Structure
- Shared header, next to the existing control/state definitions:
  - state codes ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_ACK;
  - owner codes OWNER_FETCH = 0, OWNER_DATA = 1.
- Sub-module `mem_arb_select`: takes the two requests and the last owner, and returns the winner. It contains the `MEM_ARB_ROUND_ROBIN_EN` variant.
- Top level holds the FSM, wait counter and data registers.

## Test plan
- Reset: hold `reset_n` low 2 cycles with both requests high → all outputs 0, no `mem_en`. After release, the first `mem_en` comes 1 cycle after reset deasserts.
- Fetch read, MEM_LATENCY = 2: `if_addr` = 0x0010, memory returns 0xABCD → one `mem_en` pulse with `mem_addr` 0x0010 and `mem_we` 0. `if_ack` is high exactly 4 cycles after the request is sampled, with `if_rdata` = 0xABCD. `d_ack` stays 0.
- Store: `d_we` = 1, `d_addr` = 0x0200, `d_wdata` = 0x1234 → `mem_we` = 1 and `mem_wdata` = 0x1234 during `mem_en`. `d_ack` arrives after MEM_LATENCY+2 cycles. `d_rdata` is unchanged.
- Contention, both requests held for 4 grants:
  - macro undefined: data, data, data, data;
  - macro defined: fetch, data, fetch, data.
- Reset mid-WAIT (MEM_LATENCY = 3): pull `reset_n` low in the second WAIT cycle → no ack, `busy` = 0. A new fetch afterwards completes with the correct data.
- Back-to-back: `if_req` re-asserted in the cycle after `if_ack` → exactly one IDLE cycle before the next `mem_en`. `busy` shows a single low cycle.
